// File: rtl/beta_mem_resp.sv
// beta_mem_resp: single-cycle RAM plus memory-mapped GPIO and interval timer for the Beta CPU.
// The timer, PEND and irq are compiled in only when `define TIMER_IRQ_EN is set.
module beta_mem_resp #(
    parameter int ADDR_BITS = 12
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] ma,
    input  logic [31:0] mdout,
    input  logic        mwe,
    output logic [31:0] mdin,
    output logic        irq,
    output logic [15:0] gpio_out,
    input  logic [15:0] gpio_in
);

    localparam int DEPTH = 1 << ADDR_BITS;

    localparam logic [2:0] REGION_RAM = 3'd0;
    localparam logic [2:0] REGION_IO  = 3'd1;

    localparam logic [2:0] OFF_GPIO_OUT = 3'd0;
    localparam logic [2:0] OFF_GPIO_IN  = 3'd1;
    localparam logic [2:0] OFF_COUNT    = 3'd2;
    localparam logic [2:0] OFF_RELOAD   = 3'd3;
    localparam logic [2:0] OFF_STATUS   = 3'd4;

    // No handshake: every rising edge is one transaction. The address presented
    // at an edge is answered on mdin right after that edge; mwe qualifies a write
    // at the same edge and never stalls the read.

    logic [2:0]           region;
    logic [2:0]           io_off;
    logic [ADDR_BITS-1:0] ram_idx;
    logic                 ram_sel;
    logic                 io_sel;
    logic                 io_we;

    assign region  = ma[30:28];
    assign io_off  = ma[4:2];
    assign ram_idx = ma[ADDR_BITS+1:2];
    assign ram_sel = (region == REGION_RAM);
    assign io_sel  = (region == REGION_IO);
    assign io_we   = mwe && io_sel;

    // Supervisor bit, byte offset and RAM address bits above the index alias.
    logic unused_bits;
    assign unused_bits = ^{ma[31], ma[27:ADDR_BITS+2], ma[1:0]};

    logic [31:0] ram [DEPTH];

    always_ff @(posedge clk) begin
        if (mwe && ram_sel) begin
            ram[ram_idx] <= mdout;
        end
    end

    logic [15:0] gpio_meta;
    logic [15:0] gpio_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gpio_meta <= 16'd0;
            gpio_sync <= 16'd0;
        end else begin
            gpio_meta <= gpio_in;
            gpio_sync <= gpio_meta;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gpio_out <= 16'd0;
        end else if (io_we && (io_off == OFF_GPIO_OUT)) begin
            gpio_out <= mdout[15:0];
        end
    end

    logic [31:0] count_rd;
    logic [31:0] reload_rd;
    logic [31:0] status_rd;

`ifdef TIMER_IRQ_EN
    logic        en;
    logic        pend;
    logic [31:0] count;
    logic [31:0] reload;
    logic        stat_we;
    logic        reload_we;
    logic        en_next;
    logic        en_rise;
    logic        expire;
    logic        pend_clr;

    assign stat_we   = io_we && (io_off == OFF_STATUS);
    assign reload_we = io_we && (io_off == OFF_RELOAD);
    assign en_next   = stat_we ? mdout[0] : en;
    assign en_rise   = !en && en_next;
    assign expire    = en && (count == 32'd0);
    assign pend_clr  = stat_we && mdout[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en     <= 1'b0;
            pend   <= 1'b0;
            count  <= 32'd0;
            reload <= 32'd0;
        end else begin
            en <= en_next;
            if (reload_we) begin
                reload <= mdout;
            end
            // Count reloads from the value RELOAD held before this edge, so a
            // RELOAD write only matters at the following reload.
            if (en_rise || expire) begin
                count <= reload;
            end else if (en) begin
                count <= count - 32'd1;
            end
            // Expiry beats a simultaneous software clear.
            pend <= expire | (pend & ~pend_clr);
        end
    end

    assign irq       = pend & en;
    assign count_rd  = count;
    assign reload_rd = reload;
    assign status_rd = {30'd0, pend, en};
`else
    assign irq       = 1'b0;
    assign count_rd  = 32'd0;
    assign reload_rd = 32'd0;
    assign status_rd = 32'd0;
`endif

    logic [31:0] io_rdata;

    always_comb begin
        io_rdata = 32'd0;
        case (io_off)
            OFF_GPIO_OUT: io_rdata = {16'd0, gpio_out};
            OFF_GPIO_IN:  io_rdata = {16'd0, gpio_sync};
            OFF_COUNT:    io_rdata = count_rd;
            OFF_RELOAD:   io_rdata = reload_rd;
            OFF_STATUS:   io_rdata = status_rd;
            default:      io_rdata = 32'd0;
        endcase
    end

    logic [31:0] rdata;

    always_comb begin
        rdata = 32'd0;
        if (ram_sel) begin
            rdata = ram[ram_idx];
        end else if (io_sel) begin
            rdata = io_rdata;
        end
    end

    // RAM is sampled before its write lands, giving read-first behaviour.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mdin <= 32'd0;
        end else begin
            mdin <= rdata;
        end
    end

endmodule

// File: tb/tb_beta_mem_resp.sv
// Directed bench for beta_mem_resp: behavioural model checked every cycle plus literal expectations.
`timescale 1ns/1ps
module tb_beta_mem_resp;

    localparam int AB = 12;
`ifdef TIMER_IRQ_EN
    localparam bit TIMER = 1'b1;
`else
    localparam bit TIMER = 1'b0;
`endif

    localparam logic [31:0] IDLE = 32'h4000_0000;
    localparam logic [31:0] A_GO = 32'h1000_0000;
    localparam logic [31:0] A_GI = 32'h1000_0004;
    localparam logic [31:0] A_C  = 32'h1000_0008;
    localparam logic [31:0] A_R  = 32'h1000_000C;
    localparam logic [31:0] A_S  = 32'h1000_0010;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] ma;
    logic [31:0] mdout;
    logic        mwe;
    logic [31:0] mdin;
    logic        irq;
    logic [15:0] gpio_out;
    logic [15:0] gpio_in;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [int];
    logic [15:0] m_gpio_out, m_s1, m_s2;
    logic [31:0] m_count, m_reload, exp_mdin;
    logic        m_en, m_pend, mdin_known;

    beta_mem_resp #(.ADDR_BITS(AB)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .ma       (ma),
        .mdout    (mdout),
        .mwe      (mwe),
        .mdin     (mdin),
        .irq      (irq),
        .gpio_out (gpio_out),
        .gpio_in  (gpio_in)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_gpio_out = 16'd0;
        m_s1       = 16'd0;
        m_s2       = 16'd0;
        m_count    = 32'd0;
        m_reload   = 32'd0;
        m_en       = 1'b0;
        m_pend     = 1'b0;
        exp_mdin   = 32'd0;
        mdin_known = 1'b1;
    endtask

    task automatic model_step();
        logic [2:0]  region;
        logic [2:0]  off;
        int          idx;
        logic [31:0] rd;
        bit          known;
        bit          io_we;
        bit          stat_we;
        bit          new_en;
        bit          expire;
        region = ma[30:28];
        off    = ma[4:2];
        idx    = int'(ma[AB+1:2]);
        rd     = 32'd0;
        known  = 1'b1;
        if (region == 3'd0) begin
            if (mem.exists(idx)) rd = mem[idx];
            else known = 1'b0;
        end else if (region == 3'd1) begin
            case (off)
                3'd0:    rd = {16'd0, m_gpio_out};
                3'd1:    rd = {16'd0, m_s2};
                3'd2:    rd = TIMER ? m_count : 32'd0;
                3'd3:    rd = TIMER ? m_reload : 32'd0;
                3'd4:    rd = TIMER ? {30'd0, m_pend, m_en} : 32'd0;
                default: rd = 32'd0;
            endcase
        end
        io_we = mwe && (region == 3'd1);
        if (TIMER) begin
            stat_we = io_we && (off == 3'd4);
            new_en  = stat_we ? mdout[0] : m_en;
            expire  = m_en && (m_count == 32'd0);
            if (!m_en && new_en) m_count = m_reload;
            else if (expire) m_count = m_reload;
            else if (m_en) m_count = m_count - 32'd1;
            m_pend = expire || (m_pend && !(stat_we && mdout[1]));
            m_en   = new_en;
            if (io_we && off == 3'd3) m_reload = mdout;
        end
        if (io_we && off == 3'd0) m_gpio_out = mdout[15:0];
        m_s2 = m_s1;
        m_s1 = gpio_in;
        if (mwe && region == 3'd0) mem[idx] = mdout;
        exp_mdin   = rd;
        mdin_known = known;
    endtask

    always @(posedge clk) begin
        if (reset_n === 1'b1) model_step();
    end

    // A RAM write caught by reset leaves that word undefined.
    always @(negedge reset_n) begin
        if (mwe === 1'b1 && ma[30:28] == 3'd0) mem.delete(int'(ma[AB+1:2]));
        model_reset();
    end

    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (mdin_known) check("model_mdin", mdin, exp_mdin);
            check("model_irq", 32'(irq), 32'(TIMER & m_en & m_pend));
            check("model_gpio_out", {16'd0, gpio_out}, {16'd0, m_gpio_out});
        end
    end

    task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic we);
        ma    = a;
        mdout = d;
        mwe   = we;
        @(negedge clk);
    endtask

    task automatic rd(input logic [31:0] a);
        cyc(a, 32'd0, 1'b0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        cyc(a, d, 1'b1);
    endtask

    initial begin
        reset_n = 1'b0;
        ma      = IDLE;
        mdout   = 32'd0;
        mwe     = 1'b0;
        gpio_in = 16'd0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_mdin", mdin, 32'd0);
        check("reset_irq", 32'(irq), 32'd0);
        check("reset_gpio_out", {16'd0, gpio_out}, 32'd0);
        reset_n = 1'b1;

        rd(IDLE);
        check("region4_read", mdin, 32'd0);

        wr(32'h0000_0010, 32'hDEAD_BEEF);
        rd(32'h8000_0010);
        check("ram_supervisor_alias", mdin, 32'hDEAD_BEEF);
        wr(32'h0000_0010, 32'h0000_1234);
        check("ram_read_first", mdin, 32'hDEAD_BEEF);
        rd(32'h0000_0010);
        check("ram_new_data", mdin, 32'h0000_1234);
        rd(32'h0000_4013);
        check("ram_high_and_byte_alias", mdin, 32'h0000_1234);
        wr(32'h0000_3FFC, 32'hCAFE_0001);
        rd(32'h0FFF_FFFC);
        check("ram_top_word", mdin, 32'hCAFE_0001);
        wr(32'h2000_0010, 32'hFFFF_FFFF);
        rd(32'h0000_0010);
        check("unmapped_write_ignored", mdin, 32'h0000_1234);
        rd(32'h4000_0000);
        check("unmapped_read_zero", mdin, 32'd0);

        gpio_in = 16'hA5A5;
        rd(IDLE);
        rd(IDLE);
        rd(A_GI);
        check("gpio_in_synced", mdin, 32'h0000_A5A5);
        wr(A_GO, 32'h0001_FFFF);
        check("gpio_out_trunc", {16'd0, gpio_out}, 32'h0000_FFFF);
        rd(A_GO);
        check("gpio_out_read", mdin, 32'h0000_FFFF);
        wr(A_GO, 32'h0000_5A5A);
        rd(32'h1000_0014);
        check("io_off5_zero", mdin, 32'd0);
        gpio_in = 16'h0F0F;
        rd(32'h1000_001C);
        check("io_off7_zero", mdin, 32'd0);
        rd(A_GI);

`ifdef TIMER_IRQ_EN
        wr(A_R, 32'd3);
        rd(A_R);
        check("reload_read", mdin, 32'd3);
        wr(A_S, 32'd1);
        check("en_rise_no_irq", 32'(irq), 32'd0);
        for (int i = 0; i < 3; i++) begin
            rd(A_S);
            check("timer_counting", 32'(irq), 32'd0);
        end
        rd(A_S);
        check("timer_expire_irq", 32'(irq), 32'd1);
        check("status_before_expire", mdin, 32'd1);
        wr(A_S, 32'd3);
        check("pend_cleared", 32'(irq), 32'd0);
        rd(A_S);
        check("status_after_clear", mdin, 32'd1);
        rd(A_S);
        check("irq_low_before_expire", 32'(irq), 32'd0);
        wr(A_S, 32'd3);
        check("set_wins_over_clear", 32'(irq), 32'd1);
        rd(A_C);
        check("count_after_reload", mdin, 32'd3);
        wr(A_R, 32'd7);
        rd(A_C);
        check("reload_write_no_count_change", mdin, 32'd1);
        rd(A_S);
        check("status_pend_en", mdin, 32'd3);
        wr(A_S, 32'd0);
        check("irq_masked_by_en", 32'(irq), 32'd0);
        rd(A_C);
        check("count_frozen_a", mdin, 32'd6);
        rd(A_C);
        check("count_frozen_b", mdin, 32'd6);
        rd(A_S);
        check("pend_held_when_off", mdin, 32'd2);
        wr(A_R, 32'd0);
        wr(A_S, 32'd3);
        check("restart_clears_pend", 32'(irq), 32'd0);
        for (int i = 0; i < 3; i++) begin
            wr(A_S, 32'd3);
            check("reload0_pend_every_cycle", 32'(irq), 32'd1);
        end
        begin : wait_irq
            int n;
            n = 0;
            while (irq !== 1'b1 && n < 20) begin
                rd(IDLE);
                n++;
            end
            check("irq_high_before_reset", 32'(irq), 32'd1);
        end
`else
        rd(A_C);
        check("no_timer_count_zero", mdin, 32'd0);
        wr(A_S, 32'd1);
        wr(A_R, 32'd5);
        rd(A_S);
        check("no_timer_status_zero", mdin, 32'd0);
        rd(A_R);
        check("no_timer_reload_zero", mdin, 32'd0);
        check("no_timer_irq_zero", 32'(irq), 32'd0);
`endif

        ma      = A_GO;
        mdout   = 32'h0000_7777;
        mwe     = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_irq", 32'(irq), 32'd0);
        check("async_reset_gpio_out", {16'd0, gpio_out}, 32'd0);
        check("async_reset_mdin", mdin, 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("reset_write_discarded", {16'd0, gpio_out}, 32'd0);
        ma      = IDLE;
        mwe     = 1'b0;
        reset_n = 1'b1;
        rd(32'h0000_0010);
        check("ram_survives_reset", mdin, 32'h0000_1234);
        rd(A_GO);
        check("gpio_out_after_reset", mdin, 32'd0);
        check("irq_after_reset", 32'(irq), 32'd0);
        rd(IDLE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
